// File: rtl/mc_main_fsm.sv
// Multicycle CPU main control FSM: sequences fetch/decode/execute/writeback and drives datapath selects.
// Latency: outputs are combinational from state (plus mem_ready/op/funct for handshake pulses); waits on mem_ready.
module mc_main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       ir_write,
    output logic       next_pc,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       alu_op,
    output logic [1:0] result_src,
    output logic       reg_w,
    output logic       mem_w,
    output logic       branch,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_unused;

    // Only funct[5] (imm vs reg) and funct[0] (load vs store) steer sequencing.
    assign w_unused = ^funct[4:1];
    assign state    = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = S_FETCH;
        mem_req    = 1'b0;
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 1'b0;
        result_src = 2'b00;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                next_pc    = mem_ready;
                w_next     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (op)
                    2'b00:   w_next = funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: begin
                        w_next  = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_b = 2'b01;
                w_next    = funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                w_next  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
                retire     = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                // Request and write strobe stay up for the whole wait.
                mem_req = 1'b1;
                adr_src = 1'b1;
                mem_w   = 1'b1;
                retire  = mem_ready;
                w_next  = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECR: begin
                alu_src_b = 2'b00;
                alu_op    = 1'b1;
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_b = 2'b01;
                alu_op    = 1'b1;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = 2'b00;
                reg_w      = 1'b1;
                retire     = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
                retire     = 1'b1;
                w_next     = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

endmodule
